// File: rtl/ones_comp_serial_sub_pkg.sv
// Shared definitions for the ones-complement bit-serial subtractor:
// controller state encoding and the default operand width.
package ones_comp_serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    WRAP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ones_comp_serial_sub_fa.sv
// Single-bit full adder, shared by both serial passes of the subtractor.
module ones_comp_serial_sub_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Carry
);

  // Plain combinational sum and carry.
  always_comb begin
    Y     = A ^ B ^ Cin;
    Carry = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule

// File: rtl/ones_comp_serial_sub.sv
// Ones-complement bit-serial subtractor: Diff = A - B computed as A + ~B
// in one LSB-first pass (SUB), followed by a second pass (WRAP) that adds
// the end-around carry. Latency is fixed at 2*WIDTH+1 cycles from Start.
// Optional feature macro: ONES_COMP_OVF_EN adds the Ovf output.
//
// Handshake: Start is a request pulse honoured only when Busy=0 (IDLE);
// Valid is a one-cycle pulse, and Diff (and Ovf) stay valid and stable
// until the next accepted Start completes.
module ones_comp_serial_sub
  import ones_comp_serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Busy,
  output logic             Valid,
  output state_t           dbg_state
`ifdef ONES_COMP_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
`ifdef ONES_COMP_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             nb_msb_q, nb_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic fa_b;
  logic fa_y;
  logic fa_c;

  // One adder serves both passes; in WRAP the operand bit is forced to 0.
  ones_comp_serial_sub_fa u_fa (
    .A     (sh_q[0]),
    .B     (fa_b),
    .Cin   (carry_q),
    .Y     (fa_y),
    .Carry (fa_c)
  );

  // Next-state and datapath control for the IDLE/SUB/WRAP/DONE sequence.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    fa_b    = 1'b0;
`ifdef ONES_COMP_OVF_EN
    a_msb_d  = a_msb_q;
    nb_msb_d = nb_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          sh_d    = A;
          op_d    = ~B;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SUB;
`ifdef ONES_COMP_OVF_EN
          a_msb_d  = A[WIDTH-1];
          nb_msb_d = ~B[WIDTH-1];
`endif
        end
      end
      SUB: begin
        fa_b    = op_q[0];
        sh_d    = {fa_y, sh_q[WIDTH-1:1]};
        op_d    = op_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // carry_d now holds the end-around carry for the WRAP pass
          cnt_d   = '0;
          state_d = WRAP;
        end
      end
      WRAP: begin
        fa_b    = 1'b0;
        sh_d    = {fa_y, sh_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Negative zero is passed through unchanged.
        diff_d  = sh_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef ONES_COMP_OVF_EN
        ovf_d = (a_msb_q == nb_msb_q) && (sh_q[WIDTH-1] != a_msb_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ONES_COMP_OVF_EN
      a_msb_q  <= 1'b0;
      nb_msb_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef ONES_COMP_OVF_EN
      a_msb_q  <= a_msb_d;
      nb_msb_q <= nb_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign Diff      = diff_q;
  assign Busy      = busy_q;
  assign Valid     = valid_q;
  assign dbg_state = state_q;
`ifdef ONES_COMP_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: doc/ones_comp_serial_sub.md
ONES_COMP_SERIAL_SUB -- requirements
Module: ones_comp_serial_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (2..16).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Start  input  1  request pulse; operands sampled in the same cycle.
REQ-005 A  input  WIDTH  minuend, ones-complement signed.
REQ-006 B  input  WIDTH  subtrahend, ones-complement signed.
REQ-007 Diff  output  WIDTH  registered result A - B, ones-complement.
REQ-008 Busy  output  1  high while a subtraction is in progress.
REQ-009 Valid  output  1  one-cycle pulse; Diff is valid and held until the next accepted Start.
REQ-010 Ovf  output  1  overflow flag, present only with ONES_COMP_OVF_EN.

Function
REQ-011 States: IDLE, SUB, WRAP, DONE; IDLE is the only state that accepts Start.
REQ-012 IDLE with Start=1: latch A into the shift register and ~B into the operand register, clear the carry flop, clear the bit counter, go to SUB, assert Busy.
REQ-013 SUB: one bit per cycle, LSB first, through one full adder; sum bit shifted in at the MSB; carry registered; WIDTH cycles.
REQ-014 End of SUB: the registered carry-out becomes the end-around carry; go to WRAP with the counter cleared.
REQ-015 WRAP: second serial pass adding the end-around carry (operand bits 0) to the partial sum; WIDTH cycles; always executed, even when the carry is 0, so latency is fixed.
REQ-016 WRAP generates no carry-out (partial sum is at most 2^WIDTH-2 whenever the carry is 1).
REQ-017 DONE: load Diff, pulse Valid for one cycle, deassert Busy, return to IDLE.
REQ-018 Latency: Start sampled at edge N gives Valid high after edge N+2*WIDTH+1; throughput is one result per 2*WIDTH+2 cycles.
REQ-019 Start while Busy=1 is ignored; in-flight operands are not disturbed.
REQ-020 Start in the cycle Valid is high (IDLE) is accepted normally.
REQ-021 Negative zero (all ones) is a legal result and is not normalized.
REQ-022 Diff keeps its old value during SUB/WRAP; it updates only in DONE.

Reset
REQ-023 rst_n=0 at any clk edge, including mid-operation: state IDLE, Diff=0, Busy=0, Valid=0, Ovf=0, carry/counter/shift registers 0; the in-flight operation is discarded with no Valid.
REQ-024 Start is ignored in any cycle where rst_n=0.

Configuration
REQ-025 Macro ONES_COMP_OVF_EN defined: Ovf port exists; it is loaded in DONE as (A[MSB]==~B[MSB]) && (Diff[MSB]!=A[MSB]) using the latched operands, and held with Diff.
REQ-026 Macro undefined: no Ovf port, no sign-capture flops; all other behaviour is identical.

Structure
REQ-027 A shared package holds the state enum type (IDLE/SUB/WRAP/DONE) and the default-width constant.
REQ-028 One sub-module: the existing single-bit full adder (A, B, Cin -> Y, Carry), instantiated once and reused in both passes.
REQ-029 The counter is $clog2(WIDTH)+1 bits wide; no combinational path from Start to any output.

Verification (WIDTH=4)
REQ-030 A=0101, B=0011, Start -> Valid after 9 cycles, Diff=0010, Ovf=0.
REQ-031 A=0011, B=0101 -> Diff=1101 (-2), no end-around carry, Ovf=0.
REQ-032 A=0110, B=0110 -> Diff=1111 (negative zero), Ovf=0.
REQ-033 A=0111, B=1000 -> Diff=1110, Ovf=1 (macro on); Ovf port absent (macro off).
REQ-034 Start pulsed again 3 cycles after acceptance with new operands -> ignored; the first result is returned unchanged, with a single Valid.
REQ-035 rst_n=0 in the 4th SUB cycle -> next cycle Busy=0, Diff=0000, no Valid; a following Start runs a full 9-cycle operation.
